// File: rtl/result_ascii_tx.sv
// result_ascii_tx: converts a latched signed 64-bit result to decimal ASCII and
// feeds it byte-by-byte to a UART transmitter. Define RESULT_TX_CRLF_EN to append CR LF.
module result_ascii_tx #(
  parameter int WAIT_CYC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] result,
  input  logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        ready,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_SIGN,
    S_DIGIT,
    S_WAIT,
`ifdef RESULT_TX_CRLF_EN
    S_EOL,
`endif
    S_DONE
  } state_t;

  // What was emitted last, so WAIT knows where to go once the line is free.
  typedef enum logic [1:0] {
    K_SIGN,
    K_DIGIT
`ifdef RESULT_TX_CRLF_EN
    ,
    K_CR,
    K_LF
`endif
  } kind_t;

  localparam int CW = $clog2(WAIT_CYC + 2);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYC);

  state_t        state_q, state_d;
  kind_t         last_q, last_d;
  logic [63:0]   mag_q, mag_d;
  logic [79:0]   bcd_q, bcd_d;
  logic          neg_q, neg_d;
  logic [5:0]    shift_cnt_q, shift_cnt_d;
  logic [4:0]    digit_idx_q, digit_idx_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]    tx_hold_q;
  logic [7:0]    byte_out;
  logic [79:0]   bcd_shift;
  logic [63:0]   mag_shift;

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [79:0] dabble_adjust(input logic [79:0] b);
    logic [79:0] r;
    r = b;
    for (int i = 0; i < 20; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Position of the most significant non-zero digit; 0 for a zero magnitude.
  function automatic logic [4:0] msd_index(input logic [79:0] b);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 20; i++) begin
      if (b[i*4 +: 4] != 4'd0) idx = 5'(i);
    end
    return idx;
  endfunction

  logic [79:0] bcd_adj;
  assign bcd_adj   = dabble_adjust(bcd_q);
  assign bcd_shift = {bcd_adj[78:0], mag_q[63]};
  assign mag_shift = {mag_q[62:0], 1'b0};

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    neg_d       = neg_q;
    shift_cnt_d = shift_cnt_q;
    digit_idx_d = digit_idx_q;
    wait_cnt_d  = wait_cnt_q;
    byte_out    = 8'h00;
    tx_en       = 1'b0;
    ready       = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          neg_d       = result[63];
          mag_d       = result[63] ? (~result + 64'd1) : result;
          bcd_d       = '0;
          shift_cnt_d = '0;
          state_d     = S_CONV;
        end
      end

      S_CONV: begin
        mag_d       = mag_shift;
        bcd_d       = bcd_shift;
        shift_cnt_d = shift_cnt_q + 6'd1;
        if (shift_cnt_q == 6'd63) begin
          digit_idx_d = msd_index(bcd_shift);
          state_d     = neg_q ? S_SIGN : S_DIGIT;
        end
      end

      S_SIGN: begin
        tx_en      = 1'b1;
        byte_out   = 8'h2D;
        last_d     = K_SIGN;
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end

      S_DIGIT: begin
        tx_en      = 1'b1;
        byte_out   = 8'h30 + {4'h0, bcd_q[{digit_idx_q, 2'b00} +: 4]};
        last_d     = K_DIGIT;
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (wait_cnt_q != WAIT_LAST) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end else if (!busy) begin
          case (last_q)
            K_SIGN: state_d = S_DIGIT;
            K_DIGIT: begin
              if (digit_idx_q == 5'd0) begin
`ifdef RESULT_TX_CRLF_EN
                state_d = S_EOL;
`else
                state_d = S_DONE;
`endif
              end else begin
                digit_idx_d = digit_idx_q - 5'd1;
                state_d     = S_DIGIT;
              end
            end
`ifdef RESULT_TX_CRLF_EN
            K_CR:    state_d = S_EOL;
            K_LF:    state_d = S_DONE;
`endif
            default: state_d = S_DONE;
          endcase
        end
      end

`ifdef RESULT_TX_CRLF_EN
      S_EOL: begin
        tx_en      = 1'b1;
        wait_cnt_d = '0;
        state_d    = S_WAIT;
        if (last_q == K_DIGIT) begin
          byte_out = 8'h0D;
          last_d   = K_CR;
        end else begin
          byte_out = 8'h0A;
          last_d   = K_LF;
        end
      end
`endif

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // tx_data shows the live byte during the strobe and the previous byte otherwise.
  assign tx_data = tx_en ? byte_out : tx_hold_q;

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      last_q      <= K_SIGN;
      mag_q       <= '0;
      bcd_q       <= '0;
      neg_q       <= 1'b0;
      shift_cnt_q <= '0;
      digit_idx_q <= '0;
      wait_cnt_q  <= '0;
      tx_hold_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      neg_q       <= neg_d;
      shift_cnt_q <= shift_cnt_d;
      digit_idx_q <= digit_idx_d;
      wait_cnt_q  <= wait_cnt_d;
      if (tx_en) tx_hold_q <= byte_out;
    end
  end

endmodule

// File: tb/tb_result_ascii_tx.sv
// Self-checking bench for result_ascii_tx: table vectors, corner sequences and
// randomized results compared against a decimal-formatting reference model.
module tb_result_ascii_tx;

  localparam int WAIT_CYC = 4;
  localparam int TIMEOUT  = 6000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] result;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        ready;
  logic        done;

  result_ascii_tx #(.WAIT_CYC(WAIT_CYC)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .result (result),
    .busy   (busy),
    .tx_data(tx_data),
    .tx_en  (tx_en),
    .ready  (ready),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] value;
    string       text;
    int          bdelay;
    int          blen;
  } vec_t;

  int   n_vec  = 0;
  int   n_fail = 0;
  byte  exp_q[$];
  byte  got_q[$];
  int   done_cnt = 0;
  int   viol     = 0;
  int   cyc      = 0;
  int   last_en_cyc = -1000;
  logic prev_en  = 1'b0;
  byte  last_byte = 8'h00;
  int   busy_delay = 2;
  int   busy_len   = 10;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference model: decimal text of a signed 64-bit value, built digit by digit.
  function automatic void model_fill(input logic [63:0] v);
    longint unsigned mag;
    exp_q.delete();
    mag = v[63] ? (64'd0 - v) : v;
    do begin
      exp_q.push_front(byte'(8'h30 + 8'(mag % 64'd10)));
      mag = mag / 64'd10;
    end while (mag != 0);
    if (v[63]) exp_q.push_front(8'h2D);
`ifdef RESULT_TX_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endfunction

  function automatic void fill_from_string(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(byte'(s[i]));
`ifdef RESULT_TX_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endfunction

  // Output monitor: captures bytes and flags protocol violations.
  always @(negedge clk) begin
    cyc++;
    if (!reset) last_byte = 8'h00;
    if (tx_en) begin
      got_q.push_back(tx_data);
      if (prev_en) viol++;
      if (busy) viol++;
      if (cyc - last_en_cyc < WAIT_CYC + 2) viol++;
      last_en_cyc = cyc;
      last_byte = tx_data;
    end else if (reset && tx_data !== last_byte) begin
      viol++;
    end
    prev_en = tx_en;
    if (done) begin
      done_cnt++;
      if (busy) viol++;
    end
  end

  // UART stand-in: goes busy busy_delay cycles after each strobe, for busy_len cycles.
  initial begin
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_en && reset) begin
        repeat (busy_delay) @(negedge clk);
        busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        busy = 1'b0;
      end
    end
  end

  task automatic run_txn(input logic [63:0] v, input string name);
    int t;
    t = 0;
    while (!(ready && !busy) && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    check({name, " ready"}, 64'(ready), 64'd1);
    result = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    got_q.delete();
    done_cnt = 0;
    viol     = 0;
    last_en_cyc = -1000;
    check({name, " accepted"}, 64'(ready), 64'd0);
    t = 0;
    while (done_cnt == 0 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    check({name, " done before timeout"}, 64'(t < TIMEOUT), 64'd1);
    repeat (WAIT_CYC + 30) @(negedge clk);
    check({name, " byte count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s byte%0d", name, i),
            (i < got_q.size()) ? 64'(got_q[i]) : 64'hFFFF, 64'(exp_q[i]));
    end
    check({name, " done pulses"}, 64'(done_cnt), 64'd1);
    check({name, " protocol"}, 64'(viol), 64'd0);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{64'hC000000000000000, "-4611686018427387904", 2, 10};
    tbl[1] = '{64'd0,                "0",                    2, 3};
    tbl[2] = '{64'h8000000000000000, "-9223372036854775808", 1, 5};
    tbl[3] = '{64'h7FFFFFFFFFFFFFFF, "9223372036854775807",  3, 2};
    tbl[4] = '{64'hFFFFFFFFFFFFFFFF, "-1",                   2, 8};
    tbl[5] = '{64'd10,               "10",                   1, 1};
    tbl[6] = '{64'd1000000,          "1000000",              2, 4};
    tbl[7] = '{64'hFFFFFFFFFFFFFFF6, "-10",                  2, 6};
    tbl[8] = '{64'd1234567890123456789, "1234567890123456789", 1, 0};
    tbl[9] = '{64'd9,                "9",                    3, 7};

    reset  = 1'b0;
    start  = 1'b0;
    result = '0;
    repeat (3) @(negedge clk);
    check("reset ready",   64'(ready),   64'd1);
    check("reset tx_en",   64'(tx_en),   64'd0);
    check("reset done",    64'(done),    64'd0);
    check("reset tx_data", 64'(tx_data), 64'h00);
    reset = 1'b1;

    // First start lands on the first edge after reset release.
    for (int i = 0; i < 10; i++) begin
      busy_delay = tbl[i].bdelay;
      busy_len   = tbl[i].blen;
      fill_from_string(tbl[i].text);
      run_txn(tbl[i].value, $sformatf("tbl%0d", i));
    end

    // Long busy stall with start pulses that must be ignored.
    busy_delay = 2;
    busy_len   = 200;
    fill_from_string("7");
    fork
      run_txn(64'd7, "stall");
      begin
        repeat (80) @(negedge clk);
        check("stall not ready", 64'(ready), 64'd0);
        result = 64'd5;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (60) @(negedge clk);
        result = 64'hFFFFFFFFFFFFFFFF;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
      end
    join

    // Reset in the middle of 12345.
    begin
      int t;
      busy_delay = 2;
      busy_len   = 4;
      t = 0;
      while (!(ready && !busy) && t < TIMEOUT) begin
        @(negedge clk);
        t++;
      end
      result = 64'd12345;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      got_q.delete();
      t = 0;
      while (got_q.size() < 3 && t < TIMEOUT) begin
        @(negedge clk);
        t++;
      end
      check("abort third byte", (got_q.size() >= 3) ? 64'(got_q[2]) : 64'hFFFF, 64'h33);
      reset = 1'b0;
      #1;
      check("abort tx_en",   64'(tx_en),   64'd0);
      check("abort ready",   64'(ready),   64'd1);
      check("abort done",    64'(done),    64'd0);
      check("abort tx_data", 64'(tx_data), 64'h00);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      got_q.delete();
      done_cnt = 0;
      repeat (300) @(negedge clk);
      check("abort no bytes", 64'(got_q.size()), 64'd0);
      check("abort no done",  64'(done_cnt),     64'd0);
    end
    fill_from_string("9");
    run_txn(64'd9, "after_abort");

    // Randomized results against the reference model.
    for (int n = 0; n < 16; n++) begin
      logic [63:0] v;
      int sel;
      int k;
      v   = {$urandom, $urandom};
      sel = $urandom_range(0, 2);
      if (sel == 1) v = v >> $urandom_range(0, 63);
      if (sel == 2) begin
        k = $urandom_range(0, 20) - 10;
        v = 64'(longint'(k));
      end
      busy_delay = $urandom_range(1, 3);
      busy_len   = $urandom_range(0, 6);
      model_fill(v);
      run_txn(v, $sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/result_ascii_tx.md
RESULT_ASCII_TX -- requirements
Module: result_ascii_tx

Interface
REQ-001 Parameter WAIT_CYC, default 4: minimum idle cycles after each tx_en pulse before busy is sampled.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to transmit result.
REQ-005 result  input  64  signed two's-complement value, sampled when start is accepted.
REQ-006 busy  input  1  high while the downstream UART transmitter is sending a byte.
REQ-007 tx_data  output  8  ASCII byte to transmit.
REQ-008 tx_en  output  1  one-cycle strobe; tx_data is valid in the same cycle.
REQ-009 ready  output  1  high when in IDLE and able to accept start.
REQ-010 done  output  1  one-cycle pulse after the last byte's busy window ends.

Function
REQ-011 States: IDLE, CONV, SIGN, DIGIT, WAIT, EOL (only when the macro is defined), DONE.
REQ-012 IDLE: ready=1; start=1 latches result and goes to CONV; start is ignored in every other state.
REQ-013 CONV: magnitude = result if result>=0, else the 64-bit unsigned value (~result+1); -2^63 converts to magnitude 2^63.
REQ-014 CONV runs double-dabble over 20 BCD digits (80 bits), one shift per cycle, exactly 64 cycles.
REQ-015 After CONV: a negative result goes to SIGN; a non-negative result goes to DIGIT.
REQ-016 SIGN emits 8'h2D ('-'), then passes through WAIT to DIGIT.
REQ-017 DIGIT emits 8'h30+digit, most significant non-zero digit first; leading zeros are suppressed.
REQ-018 A zero magnitude emits exactly one byte, 8'h30.
REQ-019 Each emitted byte is one cycle with tx_en=1 and tx_data set, followed by WAIT.
REQ-020 WAIT counts WAIT_CYC cycles, then holds until busy=0 is sampled; busy held high stalls the block indefinitely.
REQ-021 After the least significant digit's WAIT: go to EOL if the macro is defined, otherwise to DONE.
REQ-022 DONE asserts done for one cycle, then returns to IDLE.
REQ-023 tx_en is never high in two consecutive cycles; tx_data holds its last value when tx_en=0.
REQ-024 Maximum output is 20 characters ('-' plus 19 digits); the digit counter never wraps.

Reset
REQ-025 reset=0 immediately forces IDLE, tx_en=0, done=0, tx_data=8'h00, ready=1; BCD, counters and latched result are cleared.
REQ-026 Reset asserted mid-transmission aborts the sequence; no further bytes are sent after reset deasserts.
REQ-027 The first start is accepted on the first rising clk edge after reset deasserts.

Configuration
REQ-028 Macro RESULT_TX_CRLF_EN defined: after the last digit, EOL emits 8'h0D then 8'h0A, each followed by WAIT, before DONE.
REQ-029 RESULT_TX_CRLF_EN undefined: the EOL state and its logic are absent; the last digit's WAIT goes directly to DONE.

Verification
REQ-030 result=-4611686018427387904, busy responder 2 cycles after tx_en for 10 cycles -> bytes "-4611686018427387904" (20 bytes), then one done pulse.
REQ-031 result=0 -> single byte 8'h30, then done; with the macro defined -> 30 0D 0A.
REQ-032 result=64'h8000000000000000 -> "-9223372036854775808"; result=64'h7FFFFFFFFFFFFFFF -> "9223372036854775807".
REQ-033 result=7, busy held high for 200 cycles after the first byte -> done only after busy falls; no extra tx_en; start pulses while not ready are ignored.
REQ-034 Reset pulled low during the 3rd digit of 12345 -> tx_en=0 at once, ready=1, no further bytes; a new start of 9 -> "9".
